serial_even_parity_tx: RTL and testbench

- Transmit end of the even-parity link: accepts a parallel DATA_W-bit word through a valid/ready load handshake.
- Shifts the word out serially, LSB first, then appends one even-parity bit, so the total count of ones on the wire per frame is even.
- Drives the serial line that our 4-bit even-parity checker consumes. That checker yields C=0 on an error-free frame of DATA_W=3 data bits plus parity (4 wire bits).

---
 rtl/serial_even_parity_tx.sv | 128 ++++++++++++
 tb/tb_serial_even_parity_tx.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_even_parity_tx.sv
// Even-parity serial transmitter: parallel word in via valid/ready, LSB-first bits out, then parity.
// Optional START_STOP_FRAME_EN wraps each frame in a 0 start bit and 1 stop bit (idle line high).
module serial_even_parity_tx #(
  parameter int DATA_W = 4
) (
  input  logic              clock,
  input  logic              reset_b,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] data_in,
  output logic              load_ready,
  output logic              ser_out,
  output logic              ser_valid,
  output logic              busy,
  output logic              done
);

  localparam int CNT_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

`ifdef START_STOP_FRAME_EN
  typedef enum logic [2:0] {IDLE, START, SHIFT, PARITY, STOP} state_t;
  localparam state_t FIRST_ST = START;
  localparam logic   IDLE_LVL = 1'b1;
`else
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
  localparam state_t FIRST_ST = SHIFT;
  localparam logic   IDLE_LVL = 1'b0;
`endif

  state_t            state, state_d;
  logic [DATA_W-1:0] sh_q, sh_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              acc_q, acc_d;
  logic              ser_out_d, ser_valid_d, busy_d, done_d;
  logic              accept;

  always_comb begin
`ifdef START_STOP_FRAME_EN
    load_ready = (state == IDLE) || (state == STOP);
`else
    load_ready = (state == IDLE) || (state == PARITY);
`endif
  end

  assign accept = load_valid && load_ready;

  always_comb begin
    state_d = state;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    if (accept) begin
      state_d = FIRST_ST;
      sh_d    = data_in;
      cnt_d   = '0;
      acc_d   = 1'b0;
    end else begin
      case (state)
        SHIFT: begin
          sh_d  = sh_q >> 1;
          acc_d = acc_q ^ sh_q[0];
          if (cnt_q == LAST_CNT) begin
            cnt_d   = '0;
            state_d = PARITY;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
`ifdef START_STOP_FRAME_EN
        START:   state_d = SHIFT;
        PARITY:  state_d = STOP;
        STOP:    state_d = IDLE;
`else
        PARITY:  state_d = IDLE;
`endif
        default: state_d = IDLE;
      endcase
    end
  end

  // Outputs are registered, so decode them from the next state/next datapath values.
  always_comb begin
    ser_out_d   = IDLE_LVL;
    ser_valid_d = (state_d != IDLE);
    busy_d      = (state_d != IDLE);
    done_d      = 1'b0;
    case (state_d)
      SHIFT:  ser_out_d = sh_d[0];
      PARITY: begin
        ser_out_d = acc_d;
`ifndef START_STOP_FRAME_EN
        done_d    = 1'b1;
`endif
      end
`ifdef START_STOP_FRAME_EN
      START:  ser_out_d = 1'b0;
      STOP: begin
        ser_out_d = 1'b1;
        done_d    = 1'b1;
      end
`endif
      default: ser_out_d = IDLE_LVL;
    endcase
  end

  always_ff @(posedge clock or negedge reset_b) begin
    if (!reset_b) begin
      state     <= IDLE;
      sh_q      <= '0;
      cnt_q     <= '0;
      acc_q     <= 1'b0;
      ser_out   <= 1'b0;
      ser_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_d;
      sh_q      <= sh_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      ser_out   <= ser_out_d;
      ser_valid <= ser_valid_d;
      busy      <= busy_d;
      done      <= done_d;
    end
  end

endmodule

// File: tb/tb_serial_even_parity_tx.sv
// Directed bench for serial_even_parity_tx (DATA_W=4); framed scenario runs when START_STOP_FRAME_EN is defined.
module tb_serial_even_parity_tx;

  logic       clock = 1'b0;
  logic       reset_b = 1'b0;
  logic       load_valid = 1'b0;
  logic [3:0] data_in = '0;
  logic       load_ready, ser_out, ser_valid, busy, done;

  int n_cmp = 0;
  int n_bad = 0;

  serial_even_parity_tx #(.DATA_W(4)) dut (
    .clock     (clock),
    .reset_b   (reset_b),
    .load_valid(load_valid),
    .data_in   (data_in),
    .load_ready(load_ready),
    .ser_out   (ser_out),
    .ser_valid (ser_valid),
    .busy      (busy),
    .done      (done)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    #2;
    n_cmp++;
    if ({ser_out, ser_valid, busy, done, load_ready} !== 5'b00001) begin
      n_bad++;
      $display("FAIL reset_hold: got %b want 00001", {ser_out, ser_valid, busy, done, load_ready});
    end
    step();
    step();
    reset_b = 1'b1;
    step();
    n_cmp++;
`ifdef START_STOP_FRAME_EN
    if ({ser_out, ser_valid, busy, done, load_ready} !== 5'b10001) begin
      n_bad++;
      $display("FAIL reset_idle: got %b want 10001", {ser_out, ser_valid, busy, done, load_ready});
    end
`else
    if ({ser_out, ser_valid, busy, done, load_ready} !== 5'b00001) begin
      n_bad++;
      $display("FAIL reset_idle: got %b want 00001", {ser_out, ser_valid, busy, done, load_ready});
    end
`endif
  endtask

`ifndef START_STOP_FRAME_EN
  task automatic test_words();
    logic [3:0] words [3] = '{4'b1011, 4'b0000, 4'b1111};
    logic [4:0] exps  [3] = '{5'b11011, 5'b00000, 5'b01111};
    logic [4:0] seen;
    for (int w = 0; w < 3; w++) begin
      n_cmp++;
      if (load_ready !== 1'b1) begin
        n_bad++;
        $display("FAIL words_ready_idle w=%0d: got %b want 1", w, load_ready);
      end
      load_valid = 1'b1;
      data_in    = words[w];
      step();
      load_valid = 1'b0;
      data_in    = '0;
      for (int i = 0; i < 5; i++) begin
        seen[i] = ser_out;
        n_cmp++;
        if ({ser_out, ser_valid, busy, done, load_ready} !== {exps[w][i], 1'b1, 1'b1, i == 4, i == 4}) begin
          n_bad++;
          $display("FAIL words w=%0d bit=%0d: out/valid/busy/done/ready got %b want %b", w, i,
                   {ser_out, ser_valid, busy, done, load_ready}, {exps[w][i], 1'b1, 1'b1, i == 4, i == 4});
        end
        step();
      end
      n_cmp++;
      if (^seen !== 1'b0) begin
        n_bad++;
        $display("FAIL words_even w=%0d: frame %b has parity %b want 0", w, seen, ^seen);
      end
      n_cmp++;
      if ({ser_out, ser_valid, busy, done, load_ready} !== 5'b00001) begin
        n_bad++;
        $display("FAIL words_idle w=%0d: got %b want 00001", w, {ser_out, ser_valid, busy, done, load_ready});
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [9:0] exp_bits = 10'b00110_10001;
    load_valid = 1'b1;
    data_in    = 4'b0001;
    step();
    data_in = 4'b0110;
    for (int i = 0; i < 10; i++) begin
      n_cmp++;
      if ({ser_out, ser_valid, busy, done, load_ready} !==
          {exp_bits[i], 1'b1, 1'b1, (i == 4) || (i == 9), (i == 4) || (i == 9)}) begin
        n_bad++;
        $display("FAIL b2b cyc=%0d: out/valid/busy/done/ready got %b want %b", i,
                 {ser_out, ser_valid, busy, done, load_ready},
                 {exp_bits[i], 1'b1, 1'b1, (i == 4) || (i == 9), (i == 4) || (i == 9)});
      end
      step();
      if (i == 4) begin
        load_valid = 1'b0;
        data_in    = '0;
      end
    end
    n_cmp++;
    if ({ser_out, ser_valid, busy} !== 3'b000) begin
      n_bad++;
      $display("FAIL b2b_idle: got %b want 000", {ser_out, ser_valid, busy});
    end
  endtask

  task automatic test_busy_ignore();
    logic [4:0] exp_bits = 5'b00011;
    load_valid = 1'b1;
    data_in    = 4'b0011;
    step();
    data_in = 4'b1000;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) load_valid = 1'b0;
      n_cmp++;
      if ({ser_out, ser_valid, done} !== {exp_bits[i], 1'b1, i == 4}) begin
        n_bad++;
        $display("FAIL busy_ignore bit=%0d: out/valid/done got %b want %b", i,
                 {ser_out, ser_valid, done}, {exp_bits[i], 1'b1, i == 4});
      end
      step();
    end
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if ({ser_out, ser_valid, busy} !== 3'b000) begin
        n_bad++;
        $display("FAIL busy_ignore_idle cyc=%0d: got %b want 000", i, {ser_out, ser_valid, busy});
      end
      step();
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [4:0] exp_a = 5'b01010;
    logic [4:0] exp_b = 5'b00101;
    load_valid = 1'b1;
    data_in    = 4'b1010;
    step();
    load_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      n_cmp++;
      if ({ser_out, ser_valid} !== {exp_a[i], 1'b1}) begin
        n_bad++;
        $display("FAIL midrst_pre bit=%0d: got %b want %b", i, {ser_out, ser_valid}, {exp_a[i], 1'b1});
      end
      if (i == 0) step();
    end
    #3;
    reset_b = 1'b0;
    #1;
    n_cmp++;
    if ({ser_out, ser_valid, busy, done, load_ready} !== 5'b00001) begin
      n_bad++;
      $display("FAIL midrst_async: got %b want 00001", {ser_out, ser_valid, busy, done, load_ready});
    end
    step();
    reset_b = 1'b1;
    step();
    n_cmp++;
    if ({ser_out, ser_valid, busy} !== 3'b000) begin
      n_bad++;
      $display("FAIL midrst_no_resume: got %b want 000", {ser_out, ser_valid, busy});
    end
    load_valid = 1'b1;
    data_in    = 4'b0101;
    step();
    load_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if ({ser_out, ser_valid, done} !== {exp_b[i], 1'b1, i == 4}) begin
        n_bad++;
        $display("FAIL midrst_post bit=%0d: got %b want %b", i, {ser_out, ser_valid, done}, {exp_b[i], 1'b1, i == 4});
      end
      step();
    end
    n_cmp++;
    if ({ser_out, ser_valid} !== 2'b00) begin
      n_bad++;
      $display("FAIL midrst_post_idle: got %b want 00", {ser_out, ser_valid});
    end
  endtask
`else
  task automatic test_framed();
    logic [6:0] exp_bits = 7'b1110110;
    load_valid = 1'b1;
    data_in    = 4'b1011;
    step();
    load_valid = 1'b0;
    for (int i = 0; i < 7; i++) begin
      n_cmp++;
      if ({ser_out, ser_valid, done, load_ready} !== {exp_bits[i], 1'b1, i == 6, i == 6}) begin
        n_bad++;
        $display("FAIL framed bit=%0d: out/valid/done/ready got %b want %b", i,
                 {ser_out, ser_valid, done, load_ready}, {exp_bits[i], 1'b1, i == 6, i == 6});
      end
      step();
    end
    n_cmp++;
    if ({ser_out, ser_valid, busy, load_ready} !== 4'b1001) begin
      n_bad++;
      $display("FAIL framed_idle: got %b want 1001", {ser_out, ser_valid, busy, load_ready});
    end
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
`ifndef START_STOP_FRAME_EN
    test_words();
    test_back_to_back();
    test_busy_ignore();
    test_reset_mid_frame();
`else
    test_framed();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
